mac_accumulator: RTL and testbench

- Consumes the stream of signed 32-bit int8×int8 products from the multiplier stage and accumulates one kernel window (terminated by in_last) on top of a per-window bias.
- At window end, applies optional ReLU, a rounding arithmetic right shift and signed saturation, then presents the int8 activation plus the raw accumulator on a valid/ready output.
- Sits between the multiplier array and the activation write-back buffer.

---
 rtl/accel_pkg.sv | 17 +
 rtl/mac_accumulator_requant_sat.sv | 42 ++++
 rtl/mac_accumulator.sv | 143 ++++++++++++++
 tb/tb_mac_accumulator.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/accel_pkg.sv
// Shared widths and state encoding for the multiplier, accumulator and write-back stages.
// Keeping them in one place lets the stages agree on product/accumulator/activation sizes.
package accel_pkg;

  localparam int PROD_W  = 32;
  localparam int ACC_W   = 32;
  localparam int ACT_W   = 8;
  localparam int SHIFT_W = 5;
  localparam int CNT_W   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/mac_accumulator_requant_sat.sv
// requant_sat: combinational ReLU, round-half-up arithmetic right shift and signed saturation.
// Zero latency; no flow control, the caller decides when the result is captured.
module requant_sat #(
  parameter int ACC_W   = 32,
  parameter int OUT_W   = 8,
  parameter int SHIFT_W = 5
) (
  input  logic [ACC_W-1:0]   acc_i,
  input  logic               relu_i,
  input  logic [SHIFT_W-1:0] shift_i,
  output logic [OUT_W-1:0]   q_o
);

  localparam logic signed [ACC_W:0] Q_MAX = {{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] Q_MIN = {{(ACC_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic [ACC_W:0]        ONE   = {{ACC_W{1'b0}}, 1'b1};

  logic [ACC_W-1:0]        relu_v;
  logic signed [ACC_W:0]   v_ext;
  logic signed [ACC_W:0]   rnd;
  logic signed [ACC_W:0]   shd;

  // One guard bit keeps v + 2^(shift-1) from wrapping near the positive limit.
  always_comb begin
    relu_v = (relu_i && acc_i[ACC_W-1]) ? '0 : acc_i;
    v_ext  = {relu_v[ACC_W-1], relu_v};
    rnd    = v_ext;
    shd    = v_ext;
    if (shift_i != '0) begin
      rnd = v_ext + $signed(ONE << (shift_i - SHIFT_W'(1)));
      shd = rnd >>> shift_i;
    end
    if (shd > Q_MAX) begin
      q_o = Q_MAX[OUT_W-1:0];
    end else if (shd < Q_MIN) begin
      q_o = Q_MIN[OUT_W-1:0];
    end else begin
      q_o = shd[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/mac_accumulator.sv
// Accumulates one window of signed products on a bias, then emits requantized int8 + raw acc.
// Result one cycle after the last beat; holds output until out_ready, input stalled meanwhile.
module mac_accumulator
  import accel_pkg::*;
#(
  parameter int IN_W    = accel_pkg::PROD_W,
  parameter int ACC_W   = accel_pkg::ACC_W,
  parameter int OUT_W   = accel_pkg::ACT_W,
  parameter int SHIFT_W = accel_pkg::SHIFT_W,
  parameter int CNT_W   = accel_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    in_data,
  input  logic               in_last,
  input  logic [ACC_W-1:0]   bias,
  input  logic               cfg_relu,
  input  logic [SHIFT_W-1:0] cfg_shift,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic [ACC_W-1:0]   out_acc,
  output logic [CNT_W-1:0]   out_cnt,
  output logic               out_sat
);

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t             state_q;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               sat_q;
  logic               relu_q;
  logic [SHIFT_W-1:0] shift_q;

  logic               first;
  logic               beat_fire;
  logic [ACC_W-1:0]   acc_base;
  logic signed [ACC_W:0] sum_ext;
  logic               ovf;
  logic [ACC_W-1:0]   acc_d;
  logic [CNT_W-1:0]   cnt_d;
  logic               sat_d;
  logic               relu_d;
  logic [SHIFT_W-1:0] shift_d;
  logic [OUT_W-1:0]   q_d;

  assign in_ready  = (state_q != OUT);
  assign first     = (state_q == IDLE);
  assign beat_fire = in_valid & in_ready;

  // The first beat of a window starts from the bias and uses the live config inputs.
  always_comb begin
    acc_base = first ? bias : acc_q;
    sum_ext  = $signed({acc_base[ACC_W-1], acc_base})
             + $signed({{(ACC_W+1-IN_W){in_data[IN_W-1]}}, in_data});
    ovf      = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
    acc_d    = sum_ext[ACC_W-1:0];
    if (ovf) begin
      acc_d = sum_ext[ACC_W] ? ACC_MIN : ACC_MAX;
    end
    sat_d    = ovf | (first ? 1'b0 : sat_q);
    cnt_d    = CNT_W'(1);
    if (!first) begin
      cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    end
    relu_d   = first ? cfg_relu  : relu_q;
    shift_d  = first ? cfg_shift : shift_q;
  end

  requant_sat #(
    .ACC_W   (ACC_W),
    .OUT_W   (OUT_W),
    .SHIFT_W (SHIFT_W)
  ) u_requant (
    .acc_i   (acc_d),
    .relu_i  (relu_d),
    .shift_i (shift_d),
    .q_o     (q_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
      relu_q    <= 1'b0;
      shift_q   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_acc   <= '0;
      out_cnt   <= '0;
      out_sat   <= 1'b0;
    end else if (clear) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state_q)
        IDLE, ACC: begin
          if (beat_fire) begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            relu_q  <= relu_d;
            shift_q <= shift_d;
            if (in_last) begin
              state_q   <= OUT;
              out_valid <= 1'b1;
              out_data  <= q_d;
              out_acc   <= acc_d;
              out_cnt   <= cnt_d;
              out_sat   <= sat_d;
            end else begin
              state_q <= ACC;
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            state_q   <= IDLE;
            out_valid <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator with hand-computed expected results.
module tb_mac_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic [31:0] bias;
  logic        cfg_relu;
  logic [4:0]  cfg_shift;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [31:0] out_acc;
  logic [15:0] out_cnt;
  logic        out_sat;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mac_accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .bias      (bias),
    .cfg_relu  (cfg_relu),
    .cfg_shift (cfg_shift),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_acc   (out_acc),
    .out_cnt   (out_cnt),
    .out_sat   (out_sat)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Config applies to every beat; the DUT samples it only on the first one.
  task automatic send(input int d, input bit last, input int b, input bit relu, input int sh);
    in_valid  = 1'b1;
    in_data   = 32'(d);
    in_last   = last;
    bias      = 32'(b);
    cfg_relu  = relu;
    cfg_shift = 5'(sh);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic check_result(input string tag, input int acc, input int q,
                              input int cnt, input bit sat);
    check({tag, "_vld"}, longint'(out_valid), 1);
    check({tag, "_acc"}, longint'($signed(out_acc)), longint'(acc));
    check({tag, "_dat"}, longint'($signed(out_data)), longint'(q));
    check({tag, "_cnt"}, longint'(out_cnt), longint'(cnt));
    check({tag, "_sat"}, longint'(out_sat), longint'(sat));
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    bias = '0; cfg_relu = 1'b0; cfg_shift = '0; out_ready = 1'b0;
    #12;
    check("rst_vld", longint'(out_valid), 0);
    check("rst_dat", longint'(out_data), 0);
    check("rst_acc", longint'(out_acc), 0);
    check("rst_cnt", longint'(out_cnt), 0);
    check("rst_sat", longint'(out_sat), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_rdy", longint'(in_ready), 1);

    // Plain sum, checked one cycle after the last beat.
    send(100, 0, 0, 0, 0);
    send(-50, 0, 0, 0, 0);
    check("w1_mid_vld", longint'(out_valid), 0);
    send(30, 1, 0, 0, 0);
    check_result("w1", 80, 80, 3, 0);
    check("w1_rdy", longint'(in_ready), 0);
    take();
    check("w1_done_vld", longint'(out_valid), 0);

    // Rounding shift, output saturates high but the accumulator does not.
    send(16129, 0, 0, 0, 7);
    send(16129, 0, 0, 0, 7);
    send(16129, 1, 0, 0, 7);
    check_result("w2", 48387, 127, 3, 0);
    take();

    send(100, 1, -300, 1, 0);
    check_result("w3r", -200, 0, 1, 0);
    take();
    send(100, 1, -300, 0, 0);
    check_result("w3n", -200, -128, 1, 0);
    take();

    // Accumulator saturation, then the sticky flag must not leak into the next window.
    send(32'h200, 1, 32'h7FFFFF00, 0, 0);
    check_result("w4", 32'h7FFFFFFF, 127, 1, 1);
    take();
    send(5, 1, 0, 0, 0);
    check_result("w4b", 5, 5, 1, 0);
    take();

    // Backpressure: a stray beat offered during OUT must be ignored.
    send(10, 1, 5, 0, 0);
    in_valid = 1'b1; in_data = 32'd1000; in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("bp_vld", longint'(out_valid), 1);
      check("bp_dat", longint'($signed(out_data)), 15);
      check("bp_rdy", longint'(in_ready), 0);
    end
    in_valid = 1'b0; in_last = 1'b0;
    check("bp_acc", longint'($signed(out_acc)), 15);
    take();
    check("bp_idle_rdy", longint'(in_ready), 1);
    send(-3, 1, 0, 0, 0);
    check_result("bp_next", -3, -3, 1, 0);
    take();

    // Clear mid-window drops the beat presented with it.
    send(1, 0, 0, 0, 0);
    send(2, 0, 0, 0, 0);
    clear = 1'b1; in_valid = 1'b1; in_data = 32'd50; in_last = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("clr_vld", longint'(out_valid), 0);
      @(posedge clk);
      #1;
    end
    send(7, 1, 0, 0, 0);
    check_result("clr_next", 7, 7, 1, 0);
    take();

    // Asynchronous reset mid-window wipes the held result immediately.
    send(3, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_vld", longint'(out_valid), 0);
    check("arst_dat", longint'(out_data), 0);
    check("arst_acc", longint'(out_acc), 0);
    check("arst_cnt", longint'(out_cnt), 0);
    check("arst_sat", longint'(out_sat), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(4, 1, 0, 0, 0);
    check_result("post_rst", 4, 4, 1, 0);
    take();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete, expected finish before 50000");
    $fatal(1, "timeout");
  end

endmodule
